te_block_packer: RTL

//  Parametrised instruction-block packer for the CVA6 trace-encoder connector.

---
 rtl/mure_pkg.sv | 52 +++++
 rtl/te_block_fifo.sv | 75 +++++++
 rtl/te_block_packer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mure_pkg.sv
// Shared types and widths for the CVA6 trace-encoder block packer.
// uop_entry_s : one commit-port entry {valid, pc, compressed, itype, priv}
// block_s     : one E-trace ingress block as produced by te_block_packer
// itype_e     : E-trace instruction type codes
package mure_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned CAUSE_LEN   = 5;
   localparam int unsigned ITYPE_LEN   = 3;
   localparam int unsigned PRIV_LEN    = 2;
   localparam int unsigned IRETIRE_LEN = 5;

   typedef enum logic [ITYPE_LEN-1:0] {
      ITYPE_NONE  = 3'd0,
      ITYPE_EXC   = 3'd1,
      ITYPE_INT   = 3'd2,
      ITYPE_ERET  = 3'd3,
      ITYPE_NT    = 3'd4,
      ITYPE_TAKEN = 3'd5,
      ITYPE_UNINF = 3'd6
   } itype_e;

   typedef struct packed {
      logic                valid;
      logic [XLEN-1:0]     pc;
      logic                compressed;
      itype_e              itype;
      logic [PRIV_LEN-1:0] priv;
   } uop_entry_s;

   typedef struct packed {
      logic [XLEN-1:0]        iaddr;
      logic [IRETIRE_LEN-1:0] iretire;
      logic                   ilastsize;
      itype_e                 itype;
      logic [CAUSE_LEN-1:0]   cause;
      logic [XLEN-1:0]        tval;
      logic [PRIV_LEN-1:0]    priv;
   } block_s;

   // Traps end a block without being counted in it.
   function automatic logic is_trap(input itype_e t);
      return (t == ITYPE_EXC) || (t == ITYPE_INT);
   endfunction

   // Control-flow uops are counted, then end the block.
   function automatic logic is_close(input itype_e t);
      return (t == ITYPE_ERET) || (t == ITYPE_NT) ||
             (t == ITYPE_TAKEN) || (t == ITYPE_UNINF);
   endfunction

endpackage

// File: rtl/te_block_fifo.sv
// Multi-write / multi-read circular buffer of closed trace blocks.
// clk_i, rst_ni  : clock, synchronous active-low reset (empties the buffer)
// push_cnt_i     : number of entries of push_data_i to write this cycle (caller keeps it <= free space)
// push_data_i    : blocks to write, oldest in element 0
// pop_cnt_i      : number of head entries to drop this cycle (caller keeps it <= count_o)
// rd_valid_o     : head lanes holding a block, contiguous from lane 0
// rd_data_o      : head blocks, oldest on lane 0; zero on lanes without a block
// count_o        : current occupancy
module te_block_fifo
   import mure_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WR    = 3,
   parameter int unsigned RD    = 2,
   parameter int unsigned WCW   = $clog2(WR + 1),
   parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [WCW-1:0]        push_cnt_i,
   input  block_s [WR-1:0]       push_data_i,
   input  logic [CW-1:0]         pop_cnt_i,
   output logic [RD-1:0]         rd_valid_o,
   output block_s [RD-1:0]       rd_data_o,
   output logic [CW-1:0]         count_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   block_s        mem_q [DEPTH];
   logic [PW-1:0] rptr_q, rptr_d;
   logic [PW-1:0] wptr_q, wptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] widx [WR];

   always_comb begin
      rptr_d  = rptr_q + PW'(pop_cnt_i);
      wptr_d  = wptr_q + PW'(push_cnt_i);
      count_d = count_q - pop_cnt_i + CW'(push_cnt_i);
      for (int unsigned i = 0; i < WR; i++) begin
         widx[i] = wptr_q + PW'(i);
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < RD; i++) begin
         rd_valid_o[i] = (CW'(i) < count_q);
         rd_data_o[i]  = rd_valid_o[i] ? mem_q[rptr_q + PW'(i)] : '0;
      end
   end

   assign count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: reads are gated by count_q.
   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < WR; i++) begin
         if (WCW'(i) < push_cnt_i) begin
            mem_q[widx[i]] <= push_data_i[i];
         end
      end
   end

endmodule

// File: rtl/te_block_packer.sv
// Instruction-block packer between CVA6 commit ports and the E-trace encoder.
// Accumulates sequential committed uops into blocks, buffers closed blocks and
// presents up to N of them per cycle under a valid/ready handshake.
// clk_i, rst_ni      : clock, synchronous active-low reset
// uop_entry_i        : NRET commit lanes, processed in order 0..NRET-1
// cause_i, tval_i    : per-lane trap cause / value
// valid_o, ready_i   : per-lane block valid (contiguous from 0); ready pops all valid lanes
// iretire_o .. iaddr_o : block fields per output lane, zero when not valid
// overflow_o         : sticky, a closed block was dropped because the buffer was full
// clear_overflow_i   : clears overflow_o (a simultaneous new drop keeps it set)
module te_block_packer
   import mure_pkg::*;
#(
   parameter int unsigned NRET  = 2,
   parameter int unsigned N     = 2,
   parameter int unsigned DEPTH = 8
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  uop_entry_s [NRET-1:0]               uop_entry_i,
   input  logic [NRET-1:0][CAUSE_LEN-1:0]      cause_i,
   input  logic [NRET-1:0][XLEN-1:0]           tval_i,
   output logic [N-1:0]                        valid_o,
   input  logic                                ready_i,
   output logic [N-1:0][IRETIRE_LEN-1:0]       iretire_o,
   output logic [N-1:0]                        ilastsize_o,
   output logic [N-1:0][ITYPE_LEN-1:0]         itype_o,
   output logic [N-1:0][CAUSE_LEN-1:0]         cause_o,
   output logic [N-1:0][XLEN-1:0]              tval_o,
   output logic [N-1:0][PRIV_LEN-1:0]          priv_o,
   output logic [N-1:0][XLEN-1:0]              iaddr_o,
   output logic                                overflow_o,
   input  logic                                clear_overflow_i
);

   localparam int unsigned NC  = NRET + 1;          // max closes per cycle
   localparam int unsigned NCW = $clog2(NC + 1);
   localparam int unsigned CW  = $clog2(DEPTH + 1);
   localparam int unsigned IW  = IRETIRE_LEN + 1;
   localparam logic [IW-1:0] IRET_MAX = IW'({IRETIRE_LEN{1'b1}});

   // Open block
   logic                   active_q,   active_d;
   logic [XLEN-1:0]        iaddr_q,    iaddr_d;
   logic [IRETIRE_LEN-1:0] iretire_q,  iretire_d;
   logic                   lastsize_q, lastsize_d;
   logic [PRIV_LEN-1:0]    priv_q,     priv_d;
   logic                   overflow_q, overflow_d;

   block_s [NC-1:0] close_blk;
   logic [NCW-1:0]  close_cnt;
   block_s          nb;
   logic [IW-1:0]   inc;

   logic [CW-1:0]   count;
   logic [CW-1:0]   pop_cnt;
   logic [CW-1:0]   space;
   logic [NCW-1:0]  push_cnt;
   logic            drop;
   logic [N-1:0]    rd_valid;
   block_s [N-1:0]  rd_data;

   // Lane walker: the *_d copies of the open block are updated lane by lane,
   // so later lanes see the effect of earlier ones within the same cycle.
   always_comb begin
      active_d   = active_q;
      iaddr_d    = iaddr_q;
      iretire_d  = iretire_q;
      lastsize_d = lastsize_q;
      priv_d     = priv_q;
      close_blk  = '0;
      close_cnt  = '0;
      nb         = '0;
      inc        = '0;
      for (int unsigned l = 0; l < NRET; l++) begin
         if (uop_entry_i[l].valid) begin
            inc = uop_entry_i[l].compressed ? IW'(1) : IW'(2);
            if (is_trap(uop_entry_i[l].itype)) begin
               nb       = '0;
               nb.itype = uop_entry_i[l].itype;
               nb.cause = cause_i[l];
               nb.tval  = tval_i[l];
               if (active_d) begin
                  nb.iaddr     = iaddr_d;
                  nb.iretire   = iretire_d;
                  nb.ilastsize = lastsize_d;
                  nb.priv      = priv_d;
               end else begin
                  nb.iaddr = uop_entry_i[l].pc;
                  nb.priv  = uop_entry_i[l].priv;
               end
               if (close_cnt < NCW'(NC)) begin
                  close_blk[close_cnt] = nb;
                  close_cnt            = close_cnt + NCW'(1);
               end
               active_d  = 1'b0;
               iretire_d = '0;
            end else begin
               // Saturation: close what we have and restart at this uop.
               if (active_d && (({1'b0, iretire_d} + inc) > IRET_MAX)) begin
                  nb           = '0;
                  nb.iaddr     = iaddr_d;
                  nb.iretire   = iretire_d;
                  nb.ilastsize = lastsize_d;
                  nb.itype     = ITYPE_NONE;
                  nb.priv      = priv_d;
                  if (close_cnt < NCW'(NC)) begin
                     close_blk[close_cnt] = nb;
                     close_cnt            = close_cnt + NCW'(1);
                  end
                  active_d = 1'b0;
               end
               if (!active_d) begin
                  active_d  = 1'b1;
                  iaddr_d   = uop_entry_i[l].pc;
                  priv_d    = uop_entry_i[l].priv;
                  iretire_d = '0;
               end
               iretire_d  = iretire_d + inc[IRETIRE_LEN-1:0];
               lastsize_d = ~uop_entry_i[l].compressed;
               if (is_close(uop_entry_i[l].itype)) begin
                  nb           = '0;
                  nb.iaddr     = iaddr_d;
                  nb.iretire   = iretire_d;
                  nb.ilastsize = lastsize_d;
                  nb.itype     = uop_entry_i[l].itype;
                  nb.cause     = cause_i[l];
                  nb.tval      = tval_i[l];
                  nb.priv      = priv_d;
                  if (close_cnt < NCW'(NC)) begin
                     close_blk[close_cnt] = nb;
                     close_cnt            = close_cnt + NCW'(1);
                  end
                  active_d  = 1'b0;
                  iretire_d = '0;
               end
            end
         end
      end
   end

   // Free space counts this cycle's pops; excess closes are dropped, oldest kept.
   always_comb begin
      pop_cnt    = ready_i ? ((count < CW'(N)) ? count : CW'(N)) : '0;
      space      = CW'(DEPTH) - count + pop_cnt;
      drop       = (32'(close_cnt) > 32'(space));
      push_cnt   = drop ? NCW'(space) : close_cnt;
      overflow_d = drop ? 1'b1 : (clear_overflow_i ? 1'b0 : overflow_q);
   end

   te_block_fifo #(
      .DEPTH (DEPTH),
      .WR    (NC),
      .RD    (N)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_cnt_i  (push_cnt),
      .push_data_i (close_blk),
      .pop_cnt_i   (pop_cnt),
      .rd_valid_o  (rd_valid),
      .rd_data_o   (rd_data),
      .count_o     (count)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         active_q   <= 1'b0;
         iaddr_q    <= '0;
         iretire_q  <= '0;
         lastsize_q <= 1'b0;
         priv_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         active_q   <= active_d;
         iaddr_q    <= iaddr_d;
         iretire_q  <= iretire_d;
         lastsize_q <= lastsize_d;
         priv_q     <= priv_d;
         overflow_q <= overflow_d;
      end
   end

   assign valid_o    = rd_valid;
   assign overflow_o = overflow_q;

   always_comb begin
      for (int unsigned i = 0; i < N; i++) begin
         iaddr_o[i]     = rd_data[i].iaddr;
         iretire_o[i]   = rd_data[i].iretire;
         ilastsize_o[i] = rd_data[i].ilastsize;
         itype_o[i]     = rd_data[i].itype;
         cause_o[i]     = rd_data[i].cause;
         tval_o[i]      = rd_data[i].tval;
         priv_o[i]      = rd_data[i].priv;
      end
   end

endmodule
